serial_thermometer_transmitter: RTL and testbench

- Parallel-to-serial counterpart of `bit_serial_adder`.
- Accepts a binary count and emits a SERIAL_INPUT_LENGTH-bit serial thermometer stream, ones first, then zeros, one bit per clock.
- Drives `bit_serial_adder` and the thermometer→2's-complement path in `serial_thermometer_binary2scomp_convertor`. The adder re-accumulates the stream to the same count, which gives a closed-loop check.

---
 rtl/serial_thermometer_transmitter.sv | 124 ++++++++++++
 tb/tb_serial_thermometer_transmitter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_thermometer_transmitter.sv
// serial_thermometer_transmitter
// Turns a binary count into a fixed-length serial thermometer frame.
// Each frame is SERIAL_INPUT_LENGTH bits long, ones first and then zeros,
// one bit per clock. A new frame can be loaded on the last bit of the
// current one, so consecutive frames run with no idle bubble.
// Optional macro SERIAL_THERM_OVF_FLAG_EN adds the `ovf` output, which
// flags frames whose requested count was clamped to SERIAL_INPUT_LENGTH.
module serial_thermometer_transmitter #(
   parameter  int SERIAL_INPUT_LENGTH = 6,
   localparam int CW = $clog2(SERIAL_INPUT_LENGTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] parallel_in,
   output logic          ready,
   output logic          serial_out,
   output logic          serial_valid,
   output logic          serial_last,
`ifdef SERIAL_THERM_OVF_FLAG_EN
   output logic          ovf,
`endif
   output logic          done
);

   localparam logic [CW-1:0] LP_N    = CW'(SERIAL_INPUT_LENGTH);
   localparam logic [CW-1:0] LP_LAST = CW'(SERIAL_INPUT_LENGTH - 1);

   typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [CW-1:0] r_idx;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_idx_next;
   logic [CW-1:0] w_cnt_next;
   logic [CW-1:0] w_cnt_clamped;
   logic          w_last_bit;
   logic          w_load;
   logic          w_over;
   logic          w_out_next;
   logic          w_valid_next;
   logic          w_lastflag_next;

   // The final bit of a frame doubles as the load window for the next frame.
   assign w_last_bit    = (r_state == S_SHIFT) && (r_idx == LP_LAST);
   assign ready         = (r_state == S_IDLE) || w_last_bit;
   assign w_load        = start && ready;
   assign w_over        = (parallel_in > LP_N);
   assign w_cnt_clamped = w_over ? LP_N : parallel_in;

   // State register plus the index/count datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         serial_last  <= 1'b0;
         done         <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_idx        <= w_idx_next;
         r_cnt        <= w_cnt_next;
         serial_out   <= w_out_next;
         serial_valid <= w_valid_next;
         serial_last  <= w_lastflag_next;
         done         <= w_lastflag_next;
      end
   end

   // Next-state: start is only honoured in IDLE or on the final frame bit.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_SHIFT;
         S_SHIFT: if (r_idx == LP_LAST) w_next_state = start ? S_SHIFT : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Next index/count and the values the output registers take at this edge.
   always_comb begin
      w_idx_next      = r_idx;
      w_cnt_next      = r_cnt;
      w_out_next      = 1'b0;
      w_valid_next    = 1'b0;
      w_lastflag_next = 1'b0;
      if (w_load) begin
         w_idx_next = '0;
         w_cnt_next = w_cnt_clamped;
      end else if (r_state == S_SHIFT) begin
         // Leaving the last bit without a reload parks the index at zero.
         w_idx_next = (r_idx == LP_LAST) ? '0 : r_idx + CW'(1);
      end
      if (w_next_state == S_SHIFT) begin
         w_valid_next    = 1'b1;
         w_out_next      = (w_idx_next < w_cnt_next);
         w_lastflag_next = (w_idx_next == LP_LAST);
      end
   end

`ifdef SERIAL_THERM_OVF_FLAG_EN
   logic r_ovf;
   logic w_ovf_next;

   // Overflow flag follows the frame it was loaded with; cleared when idle.
   always_comb begin
      w_ovf_next = 1'b0;
      if (w_load)                          w_ovf_next = w_over;
      else if (w_next_state == S_SHIFT)    w_ovf_next = r_ovf;
   end

   // Overflow flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ovf <= 1'b0;
      else     r_ovf <= w_ovf_next;
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_thermometer_transmitter.sv
// Scoreboard bench for serial_thermometer_transmitter (N = 6).
// The driver pushes the expected bits of each frame it loads; a monitor on
// the falling edge pops and compares whenever the DUT is expected to or does
// present a frame bit, and re-accumulates each frame's ones count.
module tb_serial_thermometer_transmitter;

   localparam int N  = 6;
   localparam int CW = $clog2(N) + 1;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] parallel_in;
   logic          ready;
   logic          serial_out;
   logic          serial_valid;
   logic          serial_last;
   logic          done;
`ifdef SERIAL_THERM_OVF_FLAG_EN
   logic          ovf;
`endif

   serial_thermometer_transmitter #(.SERIAL_INPUT_LENGTH(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .parallel_in  (parallel_in),
      .ready        (ready),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .serial_last  (serial_last),
`ifdef SERIAL_THERM_OVF_FLAG_EN
      .ovf          (ovf),
`endif
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit b;
      bit last;
      bit ovf;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   acc    = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Expected frame: clamp to N, ones first, last flag on bit N-1.
   task automatic push_frame(input int v);
      exp_t e;
      int   c;
      c = (v > N) ? N : v;
      for (int k = 0; k < N; k++) begin
         e.b    = (k < c);
         e.last = (k == N - 1);
         e.ovf  = (v > N);
         e.cnt  = c;
         q.push_back(e);
      end
   endtask

   // Load a frame from IDLE or the last-bit cycle; returns in the last-bit cycle.
   task automatic load(input int v);
      chk("ready_at_load", ready, 1);
      start       = 1'b1;
      parallel_in = CW'(v);
      @(posedge clk); #1;
      start       = 1'b0;
      parallel_in = '0;
      push_frame(v);
      repeat (N - 1) begin @(posedge clk); #1; end
      chk("ready_on_last_bit", ready, 1);
   endtask

   // Let the current frame end with start low.
   task automatic go_idle();
      @(posedge clk); #1;
      chk("idle_valid", serial_valid, 0);
      chk("idle_ready", ready, 1);
   endtask

   // Monitor: compare each presented bit against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (done) n_done++;
      if (rst) begin
         acc = 0;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         chk("valid_expected", serial_valid, 1);
         if (serial_valid) begin
            chk("serial_out", serial_out, e.b);
            chk("serial_last", serial_last, e.last);
            chk("done", done, e.last);
`ifdef SERIAL_THERM_OVF_FLAG_EN
            chk("ovf", ovf, e.ovf);
`endif
            acc += serial_out;
            if (e.last) begin
               chk("loopback_count", acc, e.cnt);
               acc = 0;
            end
         end
      end else if (serial_valid || done) begin
         chk("unexpected_valid", serial_valid, 0);
         chk("unexpected_done", done, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      parallel_in = '0;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_valid", serial_valid, 0);
      chk("rst_out", serial_out, 0);
      chk("rst_last", serial_last, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic frame and endpoints.
      load(4); go_idle();
      load(0); go_idle();
      load(6); go_idle();
      // Clamp, followed by an in-range frame.
      load(7); go_idle();
      load(2); go_idle();
      // Back-to-back: 3 then 5 with no bubble.
      load(3); load(5); go_idle();

      // Busy start ignored, then reset mid-frame.
      chk("ready_busy_test", ready, 1);
      start       = 1'b1;
      parallel_in = CW'(5);
      @(posedge clk); #1;
      start       = 1'b0;
      push_frame(5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("ready_mid_frame", ready, 0);
      start       = 1'b1;
      parallel_in = CW'(1);
      @(posedge clk); #1;
      start       = 1'b0;
      parallel_in = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", serial_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_out", serial_out, 0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_rst_ready", ready, 1);
      load(2); go_idle();

      // Loopback sweep over every count.
      for (int v = 0; v <= N; v++) begin
         load(v); go_idle();
      end

      for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
      chk("scoreboard_drained", q.size(), 0);
      @(negedge clk);
      chk("done_pulses", n_done, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
